// File: rtl/axi_rw_arbiter.sv
// axi_rw_arbiter: grants the shared DDR AXI port to the write or read channel one burst at a time
module axi_rw_arbiter #(
    parameter int P_MAX_CONSEC = 4,
    parameter int P_TIMEOUT    = 1024
) (
    input  logic       i_axi_clk,
    input  logic       i_rst,
    input  logic       i_ddr_init,
    input  logic       i_wr_req,
    input  logic       i_rd_req,
    input  logic       i_wr_done,
    input  logic       i_rd_done,
    output logic       o_wr_grant,
    output logic       o_rd_grant,
    output logic       o_busy,
    output logic       o_timeout,
    output logic [7:0] o_timeout_cnt
);
    localparam int CW = $clog2(P_MAX_CONSEC + 1);
    localparam int TW = $clog2(P_TIMEOUT);
    localparam logic [1:0] IDLE = 2'd0, WR = 2'd1, RD = 2'd2, GAP = 2'd3;

    logic [1:0]    state, nxt, arb_nxt;
    logic [CW-1:0] consec;
    logic [TW-1:0] wd;
    logic          arb, wd_max, done, expire;

    always_comb begin
        arb     = (state == IDLE) || (state == GAP);
        wd_max  = wd == TW'(P_TIMEOUT - 1);
        done    = (state == WR) ? i_wr_done : i_rd_done;
        expire  = !arb && wd_max && !done;
        arb_nxt = !i_ddr_init ? IDLE :
                  (i_wr_req && i_rd_req && consec == CW'(P_MAX_CONSEC)) ? RD :
                  i_wr_req ? WR : i_rd_req ? RD : IDLE;
        // a burst always ends in GAP; GAP then parks in IDLE if calibration was lost
        nxt     = arb ? arb_nxt : (done || wd_max) ? GAP : state;
    end

    always_ff @(posedge i_axi_clk) begin
        if (i_rst) begin
            state         <= IDLE;
            o_wr_grant    <= 1'b0;
            o_rd_grant    <= 1'b0;
            o_busy        <= 1'b0;
            o_timeout     <= 1'b0;
            o_timeout_cnt <= 8'd0;
            consec        <= '0;
            wd            <= '0;
        end else begin
            state      <= nxt;
            o_wr_grant <= nxt == WR;
            o_rd_grant <= nxt == RD;
            o_busy     <= (nxt == WR) || (nxt == RD);
            wd         <= arb ? '0 : wd + 1'b1;
            if (arb && nxt == WR)
                consec <= i_rd_req ? consec + 1'b1 : '0;
            if (arb && nxt == RD)
                consec <= '0;
            if (expire) begin
                o_timeout <= 1'b1;
                if (o_timeout_cnt != 8'hff)
                    o_timeout_cnt <= o_timeout_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_axi_rw_arbiter.sv
// tb_axi_rw_arbiter: directed scenarios plus random traffic against an ownership-level reference model
module tb_axi_rw_arbiter;
    localparam int MAX = 4;
    localparam int TO  = 16;

    logic       clk = 0, rst = 1, init = 0;
    logic       wr_req = 0, rd_req = 0, wr_done = 0, rd_done = 0;
    logic       wr_grant, rd_grant, busy, timeout;
    logic [7:0] timeout_cnt;

    int n_checks = 0, n_fail = 0;
    int m_own = 0, m_held = 0, m_streak = 0, m_to = 0, m_cnt = 0;

    axi_rw_arbiter #(.P_MAX_CONSEC(MAX), .P_TIMEOUT(TO)) dut (
        .i_axi_clk(clk), .i_rst(rst), .i_ddr_init(init),
        .i_wr_req(wr_req), .i_rd_req(rd_req), .i_wr_done(wr_done), .i_rd_done(rd_done),
        .o_wr_grant(wr_grant), .o_rd_grant(rd_grant), .o_busy(busy),
        .o_timeout(timeout), .o_timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    // owner: 0 none, 1 write, 2 read; m_held counts cycles the current owner has held the port
    always @(posedge clk) begin
        if (rst) begin
            m_own = 0; m_held = 0; m_streak = 0; m_to = 0; m_cnt = 0;
        end else if (m_own != 0) begin
            if (m_own == 1 ? wr_done : rd_done) m_own = 0;
            else if (m_held == TO - 1) begin
                m_own = 0; m_to = 1;
                if (m_cnt < 255) m_cnt++;
            end else m_held++;
        end else if (init) begin
            m_held = 0;
            if (wr_req && rd_req && m_streak == MAX) begin m_own = 2; m_streak = 0; end
            else if (wr_req) begin m_own = 1; m_streak = rd_req ? m_streak + 1 : 0; end
            else if (rd_req) begin m_own = 2; m_streak = 0; end
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
        check("model_wr_grant", int'(wr_grant), int'(m_own == 1));
        check("model_rd_grant", int'(rd_grant), int'(m_own == 2));
        check("model_busy", int'(busy), int'(m_own != 0));
        check("model_timeout", int'(timeout), m_to);
        check("model_timeout_cnt", int'(timeout_cnt), m_cnt);
        check("grant_exclusive", int'(wr_grant && rd_grant), 0);
    endtask

    task automatic drain;
        wr_req = 0; rd_req = 0;
        for (int i = 0; i < 60 && busy; i++) begin
            wr_done = wr_grant; rd_done = rd_grant;
            cyc;
            wr_done = 0; rd_done = 0;
        end
        check("drain_idle", int'(busy), 0);
        cyc;
    endtask

    initial begin
        logic [1:0] prev, cur;
        logic [1:0] order [10];
        int hc, ng, gaps, len, nw;
        cyc;
        check("reset_wr_grant", int'(wr_grant), 0);
        check("reset_rd_grant", int'(rd_grant), 0);
        check("reset_timeout_cnt", int'(timeout_cnt), 0);
        rst = 0; wr_req = 1; rd_req = 1;
        for (int i = 0; i < 20; i++) begin
            cyc;
            check("init_gate", int'(wr_grant | rd_grant), 0);
        end
        init = 1;
        cyc;
        check("init_first_wr", int'(wr_grant), 1);
        drain;

        wr_req = 1;
        cyc;
        wr_req = 0;
        for (int i = 0; i < 7; i++) begin
            cyc;
            check("single_held", int'(wr_grant), 1);
        end
        wr_done = 1;
        cyc;
        wr_done = 0;
        check("single_release", int'(wr_grant), 0);
        check("single_gap_busy", int'(busy), 0);
        cyc;
        check("single_idle_busy", int'(busy), 0);

        wr_req = 1; rd_req = 1; prev = 0; hc = 0; ng = 0; gaps = 0;
        for (int i = 0; i < 200 && ng < 10; i++) begin
            wr_done = prev == 2'b01 && hc == 3;
            rd_done = prev == 2'b10 && hc == 3;
            cyc;
            wr_done = 0; rd_done = 0;
            cur = {rd_grant, wr_grant};
            if (cur != 0 && prev == 0) begin
                order[ng] = cur;
                if (ng > 0) check("starve_gap", gaps, 1);
                ng++; hc = 1;
            end else if (cur != 0) hc++;
            else if (prev != 0) gaps = 1;
            else gaps++;
            prev = cur;
        end
        check("starve_count", ng, 10);
        for (int i = 0; i < ng; i++)
            check("starve_order", int'(order[i]), (i % 5 == 4) ? 2 : 1);
        drain;

        wr_req = 1;
        cyc;
        wr_req = 0;
        rd_done = 1;
        cyc;
        rd_done = 0;
        check("cross_done_held", int'(wr_grant), 1);
        for (int i = 0; i < 14; i++) cyc;
        check("collide_pre", int'(wr_grant), 1);
        wr_done = 1;
        cyc;
        wr_done = 0;
        check("collide_release", int'(wr_grant), 0);
        check("collide_no_timeout", int'(timeout), 0);
        cyc;

        rd_req = 1;
        cyc;
        rd_req = 0;
        check("wd_grant", int'(rd_grant), 1);
        len = 1;
        for (int i = 0; i < 40 && rd_grant; i++) begin
            cyc;
            if (rd_grant) len++;
        end
        check("wd_len", len, TO);
        check("wd_timeout", int'(timeout), 1);
        check("wd_cnt1", int'(timeout_cnt), 1);
        for (int r = 0; r < 299; r++) begin
            rd_req = 1;
            cyc;
            rd_req = 0;
            for (int i = 0; i < 40 && rd_grant; i++) cyc;
        end
        check("wd_saturate", int'(timeout_cnt), 255);
        check("wd_sticky", int'(timeout), 1);
        cyc;

        wr_req = 1; rd_req = 1; prev = 0; hc = 0; nw = 0;
        for (int i = 0; i < 100 && nw < 3; i++) begin
            wr_done = prev == 2'b01 && hc == 3;
            rd_done = prev == 2'b10 && hc == 3;
            cyc;
            wr_done = 0; rd_done = 0;
            cur = {rd_grant, wr_grant};
            if (cur == 2'b01 && prev == 0) begin nw++; hc = 1; end
            else if (cur != 0) hc++;
            prev = cur;
        end
        check("rst_mid_third_w", nw, 3);
        rst = 1;
        cyc;
        rst = 0;
        check("rst_mid_grants", int'(wr_grant | rd_grant), 0);
        check("rst_mid_cnt", int'(timeout_cnt), 0);
        cyc;
        check("rst_then_w", int'(wr_grant), 1);
        drain;

        for (int i = 0; i < 4000; i++) begin
            rst     = $urandom_range(0, 499) == 0;
            init    = $urandom_range(0, 15) != 0;
            wr_req  = $urandom_range(0, 9) < 6;
            rd_req  = $urandom_range(0, 9) < 6;
            wr_done = $urandom_range(0, 9) < 2;
            rd_done = $urandom_range(0, 9) < 2;
            cyc;
        end
        rst = 0; wr_done = 0; rd_done = 0;
        drain;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
